lsu: RTL and testbench

Load/store unit between the single-cycle core's datapath and a word-wide data bus with a valid/ready handshake. It takes the datapath's computed address (`aluout`) and store data (`writedata`) and drives byte-lane-aligned bus transfers. It returns sign- or zero-extended load data on `readdata` and stalls the core while a transfer is outstanding. It replaces the direct combinational data-memory connection so that memories and peripherals with multi-cycle latency can sit on the bus.

---
 rtl/lsu.sv | 173 +++++++++++++++++
 tb/tb_lsu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: bridges core address/store data to a valid/ready word bus.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] readdata_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_wstrb_q;
    logic        bus_we_q;
    logic        bus_valid_q;
    logic        fault_q;

    logic [2:0]  f3_n;
    logic [1:0]  off_n;
    logic [3:0]  wstrb_n;
    logic [31:0] wdata_n;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Illegal encodings behave as a word access.
    always_comb begin
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_n = funct3;
            default:                                f3_n = 3'b010;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((f3_n[1:0] == 2'b01) && addr[0]) ||
                      ((f3_n[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`endif

    // Offset bits below the access size are forced to zero.
    always_comb begin
        case (f3_n[1:0])
            2'b00:   off_n = addr[1:0];
            2'b01:   off_n = {addr[1], 1'b0};
            default: off_n = 2'b00;
        endcase
    end

    always_comb begin
        wstrb_n = 4'b0000;
        wdata_n = wdata;
        case (f3_n[1:0])
            2'b00: begin
                wstrb_n = 4'b0001 << off_n;
                wdata_n = {4{wdata[7:0]}};
            end
            2'b01: begin
                wstrb_n = off_n[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{wdata[15:0]}};
            end
            default: begin
                wstrb_n = 4'b1111;
                wdata_n = wdata;
            end
        endcase
        if (!mem_we) wstrb_n = 4'b0000;
    end

    always_comb begin
        ld_byte = 8'(bus_rdata >> {off_q, 3'b000});
        ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            readdata_q  <= 32'h0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_wstrb_q <= 4'b0000;
            bus_we_q    <= 1'b0;
            bus_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    fault_q <= 1'b0;
                    if (mem_req) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign) begin
                            state_q    <= StDone;
                            fault_q    <= 1'b1;
                            readdata_q <= 32'h0;
                        end else begin
`else
                        begin
`endif
                            state_q     <= StReq;
                            bus_valid_q <= 1'b1;
                            bus_addr_q  <= {addr[31:2], 2'b00};
                            bus_we_q    <= mem_we;
                            bus_wstrb_q <= wstrb_n;
                            bus_wdata_q <= wdata_n;
                            f3_q        <= f3_n;
                            off_q       <= off_n;
                            cnt_q       <= 8'(TIMEOUT_CYCLES);
                        end
                    end
                end
                StReq: begin
                    if (bus_ready) begin
                        bus_valid_q <= 1'b0;
                        if (!bus_we_q) readdata_q <= ld_data;
                        state_q <= StDone;
                    end else if (cnt_q == 8'd0) begin
                        bus_valid_q <= 1'b0;
                        fault_q     <= 1'b1;
                        readdata_q  <= 32'h0;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StDone: begin
                    fault_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall     = ((state_q == StIdle) && mem_req) || (state_q == StReq);
    assign readdata  = readdata_q;
    assign fault     = fault_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a simple delayed-ready bus slave.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  funct3 = 3'b010;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] readdata;
    logic        stall;
    logic        fault;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;

    int n_checks = 0;
    int n_pass = 0;
    int ready_delay = 0;
    int wcnt = 0;

    int          stalls, reqs;
    logic        unstable, done_fault;
    logic [31:0] sn_addr, sn_wdata;
    logic [3:0]  sn_wstrb;
    logic        sn_we;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .readdata(readdata), .stall(stall), .fault(fault),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Slave accepts after ready_delay wait cycles.
    always @(posedge clk) wcnt <= bus_valid ? wcnt + 1 : 0;
    assign bus_ready = bus_valid && (wcnt == ready_delay);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Runs one access; returns at the negedge of the DONE cycle with mem_req still high.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int dly);
        @(posedge clk); #1;
        ready_delay = dly;
        mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        stalls = 0; reqs = 0; unstable = 1'b0;
        @(negedge clk);
        while (stall && stalls < 40) begin
            stalls++;
            if (bus_valid) begin
                if (reqs == 0) begin
                    sn_addr = bus_addr; sn_we = bus_we; sn_wstrb = bus_wstrb; sn_wdata = bus_wdata;
                end else if (bus_addr !== sn_addr || bus_we !== sn_we ||
                             bus_wstrb !== sn_wstrb || bus_wdata !== sn_wdata) begin
                    unstable = 1'b1;
                end
                reqs++;
            end
            @(negedge clk);
        end
        done_fault = fault;
    endtask

    task automatic finish_access();
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_readdata", readdata, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_valid", {31'b0, bus_valid}, 32'h0);
        check("rst_we", {31'b0, bus_we}, 32'h0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_wstrb", {28'b0, bus_wstrb}, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        @(negedge clk); reset = 1'b0;

        // LW, immediate ready
        bus_rdata = 32'hDEAD_BEEF;
        access(1'b0, 3'b010, 32'h10, 32'h0, 0);
        check("lw_stalls", stalls, 2);
        check("lw_reqs", reqs, 1);
        check("lw_addr", sn_addr, 32'h10);
        check("lw_we", {31'b0, sn_we}, 32'h0);
        check("lw_wstrb", {28'b0, sn_wstrb}, 32'h0);
        check("lw_data", readdata, 32'hDEAD_BEEF);
        check("lw_fault", {31'b0, done_fault}, 32'h0);
        check("lw_valid_done", {31'b0, bus_valid}, 32'h0);
        finish_access();
        @(negedge clk);
        check("idle_stall", {31'b0, stall}, 32'h0);
        check("idle_hold", readdata, 32'hDEAD_BEEF);

        bus_rdata = 32'h80FF_0000;
        access(1'b0, 3'b000, 32'h13, 32'h0, 0);
        check("lb_data", readdata, 32'hFFFF_FF80);
        finish_access();
        access(1'b0, 3'b100, 32'h13, 32'h0, 0);
        check("lbu_data", readdata, 32'h0000_0080);
        finish_access();
        access(1'b0, 3'b001, 32'h12, 32'h0, 0);
        check("lh_data", readdata, 32'hFFFF_80FF);
        finish_access();
        access(1'b0, 3'b101, 32'h12, 32'h0, 0);
        check("lhu_data", readdata, 32'h0000_80FF);
        finish_access();

        access(1'b1, 3'b000, 32'h22, 32'h0000_00AB, 0);
        check("sb_wstrb", {28'b0, sn_wstrb}, 32'h4);
        check("sb_wdata", sn_wdata, 32'hABAB_ABAB);
        check("sb_we", {31'b0, sn_we}, 32'h1);
        check("sb_addr", sn_addr, 32'h20);
        check("sb_rd_hold", readdata, 32'h0000_80FF);
        finish_access();
        access(1'b1, 3'b001, 32'h22, 32'h5555_1234, 0);
        check("sh_wstrb", {28'b0, sn_wstrb}, 32'hC);
        check("sh_wdata", sn_wdata, 32'h1234_1234);
        finish_access();
        access(1'b1, 3'b010, 32'h30, 32'h0123_4567, 0);
        check("sw_wstrb", {28'b0, sn_wstrb}, 32'hF);
        check("sw_wdata", sn_wdata, 32'h0123_4567);
        finish_access();

        // Three wait states
        bus_rdata = 32'h0BAD_F00D;
        access(1'b0, 3'b010, 32'h40, 32'h0, 3);
        check("dly_reqs", reqs, 4);
        check("dly_stalls", stalls, 5);
        check("dly_stable", {31'b0, unstable}, 32'h0);
        check("dly_data", readdata, 32'h0BAD_F00D);
        finish_access();

        // Timeout with TIMEOUT_CYCLES=4
        access(1'b0, 3'b010, 32'h44, 32'h0, 1000);
        check("to_reqs", reqs, 5);
        check("to_stalls", stalls, 6);
        check("to_fault", {31'b0, done_fault}, 32'h1);
        check("to_data", readdata, 32'h0);
        check("to_valid", {31'b0, bus_valid}, 32'h0);
        finish_access();
        @(negedge clk);
        check("to_fault_pulse", {31'b0, fault}, 32'h0);
        check("to_idle", {31'b0, stall}, 32'h0);

        // Misaligned word
        bus_rdata = 32'h1122_3344;
        access(1'b0, 3'b010, 32'h06, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_reqs", reqs, 0);
        check("mis_stalls", stalls, 1);
        check("mis_fault", {31'b0, done_fault}, 32'h1);
        check("mis_data", readdata, 32'h0);
`else
        check("mis_reqs", reqs, 1);
        check("mis_addr", sn_addr, 32'h4);
        check("mis_fault", {31'b0, done_fault}, 32'h0);
        check("mis_data", readdata, 32'h1122_3344);
`endif
        finish_access();

        // Illegal funct3 acts as word
        bus_rdata = 32'hCAFE_F00D;
        access(1'b0, 3'b110, 32'h50, 32'h0, 0);
        check("ill_data", readdata, 32'hCAFE_F00D);
        finish_access();

        // Reset during REQ
        @(posedge clk); #1;
        ready_delay = 1000;
        mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h60;
        @(negedge clk);
        @(negedge clk);
        check("rq_valid", {31'b0, bus_valid}, 32'h1);
        reset = 1'b1; mem_req = 1'b0;
        #1;
        check("rst_rq_valid", {31'b0, bus_valid}, 32'h0);
        check("rst_rq_stall", {31'b0, stall}, 32'h0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("rst_rq_norestart", {31'b0, bus_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
